// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate type and raster phase enum.
// Consumed by vga_axis_counter and vga_timing_gen (optional macro VGA_MOVE_DIV_EN lives in the top).
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] coord_t;

  typedef enum logic [1:0] {ACT, FRONT, SYNCP, BACK} phase_t;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus its ACT/FRONT/SYNCP/BACK phase.
// Phase is a register kept in lockstep with count, so sync needs no range compare.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACT_LEN  = H_ACTIVE_DEF,
  parameter int FP_LEN   = H_FP_DEF,
  parameter int SYNC_LEN = H_SYNC_DEF,
  parameter int BP_LEN   = H_BP_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output phase_t phase,
  output logic   wrap,
  output logic   sync
);

  localparam int     TOTAL      = axis_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);
  localparam coord_t LAST_ACT   = coord_t'(ACT_LEN - 1);
  localparam coord_t LAST_FRONT = coord_t'(ACT_LEN + FP_LEN - 1);
  localparam coord_t LAST_SYNC  = coord_t'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam coord_t LAST       = coord_t'(TOTAL - 1);

  assign wrap = en && (count == LAST);
  assign sync = (phase == SYNCP);

  // Phase advances on the cycle the count leaves the last position of a region.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= ACT;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + coord_t'(1);
      if (count == LAST_ACT)        phase <= FRONT;
      else if (count == LAST_FRONT) phase <= SYNCP;
      else if (count == LAST_SYNC)  phase <= BACK;
      else if (count == LAST)       phase <= ACT;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: registered X/Y, ACTIVE, HSYNC/VSYNC and FRAME_TICK.
// Define VGA_MOVE_DIV_EN to emit FRAME_TICK only once every MOVE_DIV frames.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   MOVE_DIV    = 1
) (
  input  logic       CLK_DRAW,
  input  logic       RST,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       ACTIVE,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       FRAME_TICK
);

  if (axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > 1024) begin : g_h_range
    $error("H_TOTAL does not fit the 10-bit horizontal counter");
  end
  if (axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > 1024) begin : g_v_range
    $error("V_TOTAL does not fit the 10-bit vertical counter");
  end
  if (MOVE_DIV < 1 || MOVE_DIV > 255) begin : g_div_range
    $error("MOVE_DIV must be in 1..255");
  end

  coord_t h_cnt, v_cnt;
  phase_t h_phase, v_phase;
  logic   h_wrap, v_wrap, h_sync, v_sync;
  logic   blank_pt, tick_d;
  logic   frame_wrap_unused;

  vga_axis_counter #(
    .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
  ) u_h (
    .clk(CLK_DRAW), .rst(RST), .en(1'b1),
    .count(h_cnt), .phase(h_phase), .wrap(h_wrap), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
  ) u_v (
    .clk(CLK_DRAW), .rst(RST), .en(h_wrap),
    .count(v_cnt), .phase(v_phase), .wrap(v_wrap), .sync(v_sync)
  );

  assign frame_wrap_unused = v_wrap;

  // First pixel of vertical blanking: movement updates never tear visible video.
  assign blank_pt = (h_cnt == '0) && (v_cnt == coord_t'(V_ACTIVE));

`ifdef VGA_MOVE_DIV_EN
  localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);
  logic [7:0] div_cnt;

  assign tick_d = blank_pt && (div_cnt == DIV_LAST);

  always_ff @(posedge CLK_DRAW or posedge RST) begin
    if (RST)           div_cnt <= '0;
    else if (blank_pt) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 8'd1;
  end
`else
  assign tick_d = blank_pt;
`endif

  always_ff @(posedge CLK_DRAW or posedge RST) begin
    if (RST) begin
      X          <= '0;
      Y          <= '0;
      ACTIVE     <= 1'b0;
      HSYNC      <= ~SYNC_ACTIVE;
      VSYNC      <= ~SYNC_ACTIVE;
      FRAME_TICK <= 1'b0;
    end else begin
      X          <= h_cnt;
      Y          <= v_cnt;
      ACTIVE     <= (h_phase == ACT) && (v_phase == ACT);
      HSYNC      <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      VSYNC      <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      FRAME_TICK <= tick_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken 25x15 raster (375 clocks per frame).
// Stimulus pushes the expected output per cycle; a negedge monitor pops and compares.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int MD = 3;
  localparam int HT = 25, VT = 15, FRAME = 375;
  localparam int HS_FIRST = 18, HS_LAST = 20;
  localparam int VS_FIRST = 10, VS_LAST = 11;
`ifdef VGA_MOVE_DIV_EN
  localparam int TICK_GAP = 1125, TICKS_EXP = 2;
`else
  localparam int TICK_GAP = 375,  TICKS_EXP = 8;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       tick;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] X, Y;
  logic       ACTIVE, HSYNC, VSYNC, FRAME_TICK;

  vec_t q[$];
  int   n_vec = 0, n_bad = 0;
  int   mh = 0, mv = 0, mdiv = 0;
  int   tick_total = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .MOVE_DIV(MD)
  ) dut (
    .CLK_DRAW(clk), .RST(rst), .X(X), .Y(Y), .ACTIVE(ACTIVE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .FRAME_TICK(FRAME_TICK)
  );

  // One clock: set rst just after the edge, push what the outputs must show this cycle.
  task automatic step(input logic r);
    logic was;
    vec_t e;
    @(posedge clk);
    was = rst;
    #1;
    rst = r;
    e = '0;
    if (was || r) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      mh = 0; mv = 0; mdiv = 0;
    end else begin
      e.x   = 10'(mh);
      e.y   = 10'(mv);
      e.act = (mh < HA) && (mv < VA);
      e.hs  = !(mh >= HS_FIRST && mh <= HS_LAST);
      e.vs  = !(mv >= VS_FIRST && mv <= VS_LAST);
      if (mh == 0 && mv == VA) begin
`ifdef VGA_MOVE_DIV_EN
        e.tick = (mdiv == MD - 1);
        mdiv   = (mdiv == MD - 1) ? 0 : mdiv + 1;
`else
        e.tick = 1'b1;
`endif
      end
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    q.push_back(e);
  endtask

  int   cyc = 0, last_tick = -1, hs_low = 0, vs_lines = 0;
  logic line_ok = 1'b0, frame_ok = 1'b0, prev_hs = 1'b1;
  vec_t a, e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      a = {X, Y, ACTIVE, HSYNC, VSYNC, FRAME_TICK};
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec cyc=%0d got x=%0d y=%0d act=%b hs=%b vs=%b tick=%b want x=%0d y=%0d act=%b hs=%b vs=%b tick=%b",
                   cyc, a.x, a.y, a.act, a.hs, a.vs, a.tick, e.x, e.y, e.act, e.hs, e.vs, e.tick);
        end
      end
      if (rst) begin
        last_tick = -1; line_ok = 1'b0; frame_ok = 1'b0; hs_low = 0; vs_lines = 0;
      end else begin
        if (FRAME_TICK) begin
          tick_total++;
          if (last_tick >= 0) begin
            n_vec++;
            if (cyc - last_tick != TICK_GAP) begin
              n_bad++;
              $display("FAIL tick_gap got %0d want %0d", cyc - last_tick, TICK_GAP);
            end
          end
          last_tick = cyc;
        end
        if (!HSYNC && prev_hs) begin
          n_vec++;
          if (X != 10'(HS_FIRST)) begin
            n_bad++;
            $display("FAIL hsync_start got x=%0d want x=%0d", X, HS_FIRST);
          end
        end
        if (X == 0) begin line_ok = 1'b1; hs_low = 0; end
        if (!HSYNC) hs_low++;
        if (X == 0 && Y == 0) begin frame_ok = 1'b1; vs_lines = 0; end
        if (X == 0 && !VSYNC) vs_lines++;
        if (X == 10'(HT - 1) && line_ok) begin
          n_vec++;
          if (hs_low != HS) begin
            n_bad++;
            $display("FAIL hsync_width got %0d want %0d", hs_low, HS);
          end
        end
        if (X == 10'(HT - 1) && Y == 10'(VT - 1) && frame_ok) begin
          n_vec++;
          if (vs_lines != VS) begin
            n_bad++;
            $display("FAIL vsync_lines got %0d want %0d", vs_lines, VS);
          end
        end
      end
      prev_hs = HSYNC;
    end
  end

  initial begin
    repeat (3) step(1'b1);
    step(1'b0);                      // release; this edge still sees reset
    repeat (7 * FRAME) step(1'b0);   // seven full frames from (0,0)
    repeat (5 * HT + 11) step(1'b0); // last pushed output is (10,5)
    step(1'b1);                      // async reset mid-frame, held two edges
    step(1'b1);
    step(1'b0);
    repeat (9 * HT) step(1'b0);      // restart, through the blanking tick line
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    n_vec++;
    if (tick_total != TICKS_EXP) begin
      n_bad++;
      $display("FAIL tick_count got %0d want %0d", tick_total, TICKS_EXP);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
